// File: rtl/ps2_guess_entry_pkg.sv
// rtl/ps2_guess_entry_pkg.sv - scan-code constants, FSM states and sizing for PS/2 guess entry
package ps2_guess_entry_pkg;

    // Digits per guess; the count register is sized to hold 0..NUM_DIGITS.
    localparam int NUM_DIGITS = 3;
    localparam int CNT_W      = $clog2(NUM_DIGITS + 1);

    // PS/2 set-2 prefixes and control keys.
    localparam logic [7:0] KEY_BREAK_PFX = 8'hF0;
    localparam logic [7:0] KEY_EXT_PFX   = 8'hE0;
    localparam logic [7:0] KEY_ENTER_DEF = 8'h5A;
    localparam logic [7:0] KEY_BKSP_DEF  = 8'h66;

    // Prefix FSM: the *_BREAK states swallow the byte that follows an F0.
    typedef enum logic [1:0] {
        S_MAKE      = 2'd0,
        S_EXT       = 2'd1,
        S_BREAK     = 2'd2,
        S_EXT_BREAK = 2'd3
    } state_t;

endpackage

// File: rtl/ps2_scan_to_digit.sv
// rtl/ps2_scan_to_digit.sv - combinational PS/2 scan code to decimal digit decoder
//   code_i     in  8  PS/2 make code
//   is_digit_o out 1  code is a main-row or numpad digit
//   digit_o    out 4  decoded BCD digit (0 when is_digit_o=0)
module ps2_scan_to_digit (
    input  logic [7:0] code_i,
    output logic       is_digit_o,
    output logic [3:0] digit_o
);

    always_comb begin
        is_digit_o = 1'b1;
        digit_o    = 4'd0;
        case (code_i)
            // main row
            8'h45: digit_o = 4'd0;
            8'h16: digit_o = 4'd1;
            8'h1E: digit_o = 4'd2;
            8'h26: digit_o = 4'd3;
            8'h25: digit_o = 4'd4;
            8'h2E: digit_o = 4'd5;
            8'h36: digit_o = 4'd6;
            8'h3D: digit_o = 4'd7;
            8'h3E: digit_o = 4'd8;
            8'h46: digit_o = 4'd9;
            // numpad
            8'h70: digit_o = 4'd0;
            8'h69: digit_o = 4'd1;
            8'h72: digit_o = 4'd2;
            8'h7A: digit_o = 4'd3;
            8'h6B: digit_o = 4'd4;
            8'h73: digit_o = 4'd5;
            8'h74: digit_o = 4'd6;
            8'h6C: digit_o = 4'd7;
            8'h75: digit_o = 4'd8;
            8'h7D: digit_o = 4'd9;
            default: is_digit_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/ps2_guess_entry.sv
// rtl/ps2_guess_entry.sv - PS/2 scan-code bytes to 3-digit Bulls-and-Cows guess
//   Optional macro DISTINCT_DIGITS_EN: reject a digit already present in the buffer.
//   clk, reset          clock, asynchronous active-high reset
//   scan_code/valid     received PS/2 byte with 1-cycle strobe
//   num1..num3          last submitted guess (held until next submit)
//   num_rdy             1-cycle strobe, new guess on num1..num3
//   entry_count         digits currently buffered
//   entry_err           1-cycle strobe, key rejected
//   led                 {entry_count, num_rdy_seen, entry_err_seen, last_digit}
module ps2_guess_entry
    import ps2_guess_entry_pkg::*;
#(
    parameter logic [7:0] KEY_ENTER = KEY_ENTER_DEF,
    parameter logic [7:0] KEY_BKSP  = KEY_BKSP_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] scan_code,
    input  logic       scan_valid,
    output logic [3:0] num1,
    output logic [3:0] num2,
    output logic [3:0] num3,
    output logic       num_rdy,
    output logic [1:0] entry_count,
    output logic       entry_err,
    output logic [7:0] led
);

    state_t           state_q;
    logic [3:0]       slot_q [NUM_DIGITS];
    logic [CNT_W-1:0] count_q;
    logic [3:0]       num1_q, num2_q, num3_q, last_digit_q;
    logic             num_rdy_q, entry_err_q, rdy_seen_q, err_seen_q;

    logic       is_digit;
    logic [3:0] dec_digit;
    logic       full, dup;
    logic       enter_key, bksp_key, digit_key;

    ps2_scan_to_digit u_dec (
        .code_i     (scan_code),
        .is_digit_o (is_digit),
        .digit_o    (dec_digit)
    );

    assign full = (count_q == CNT_W'(NUM_DIGITS));

`ifdef DISTINCT_DIGITS_EN
    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((CNT_W'(i) < count_q) && (slot_q[i] == dec_digit)) dup = 1'b1;
        end
    end
`else
    assign dup = 1'b0;
`endif

    // Enter is honoured both plain and E0-prefixed (numpad Enter); digits and
    // backspace only as plain make codes.
    assign enter_key = scan_valid && (scan_code == KEY_ENTER) &&
                       ((state_q == S_MAKE) || (state_q == S_EXT));
    assign bksp_key  = scan_valid && (scan_code == KEY_BKSP) && (state_q == S_MAKE);
    assign digit_key = scan_valid && is_digit && (state_q == S_MAKE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_MAKE;
            count_q      <= '0;
            num1_q       <= 4'd0;
            num2_q       <= 4'd0;
            num3_q       <= 4'd0;
            last_digit_q <= 4'd0;
            num_rdy_q    <= 1'b0;
            entry_err_q  <= 1'b0;
            rdy_seen_q   <= 1'b0;
            err_seen_q   <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) slot_q[i] <= 4'd0;
        end else begin
            num_rdy_q   <= 1'b0;
            entry_err_q <= 1'b0;

            if (scan_valid) begin
                case (state_q)
                    S_MAKE: begin
                        if (scan_code == KEY_BREAK_PFX)    state_q <= S_BREAK;
                        else if (scan_code == KEY_EXT_PFX) state_q <= S_EXT;
                    end
                    S_EXT: begin
                        if (scan_code == KEY_BREAK_PFX) state_q <= S_EXT_BREAK;
                        else                            state_q <= S_MAKE;
                    end
                    // released key code (even a prefix byte) is dropped here
                    default: state_q <= S_MAKE;
                endcase
            end

            if (enter_key) begin
                if (full) begin
                    num1_q     <= slot_q[0];
                    num2_q     <= slot_q[1];
                    num3_q     <= slot_q[2];
                    num_rdy_q  <= 1'b1;
                    rdy_seen_q <= 1'b1;
                    count_q    <= '0;
                end else begin
                    entry_err_q <= 1'b1;
                    err_seen_q  <= 1'b1;
                end
            end

            if (bksp_key && (count_q != '0)) count_q <= count_q - 1'b1;

            if (digit_key) begin
                if (full || dup) begin
                    entry_err_q <= 1'b1;
                    err_seen_q  <= 1'b1;
                end else begin
                    slot_q[count_q] <= dec_digit;
                    count_q         <= count_q + 1'b1;
                    last_digit_q    <= dec_digit;
                    rdy_seen_q      <= 1'b0;
                    err_seen_q      <= 1'b0;
                end
            end
        end
    end

    assign num1        = num1_q;
    assign num2        = num2_q;
    assign num3        = num3_q;
    assign num_rdy     = num_rdy_q;
    assign entry_err   = entry_err_q;
    assign entry_count = count_q;
    assign led         = {count_q, rdy_seen_q, err_seen_q, last_digit_q};

endmodule

// File: tb/tb_ps2_guess_entry.sv
// tb/tb_ps2_guess_entry.sv - scoreboard bench for ps2_guess_entry
module tb_ps2_guess_entry;

    logic       clk;
    logic       reset;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic [3:0] num1, num2, num3;
    logic       num_rdy, entry_err;
    logic [1:0] entry_count;
    logic [7:0] led;

    ps2_guess_entry dut (
        .clk         (clk),
        .reset       (reset),
        .scan_code   (scan_code),
        .scan_valid  (scan_valid),
        .num1        (num1),
        .num2        (num2),
        .num3        (num3),
        .num_rdy     (num_rdy),
        .entry_count (entry_count),
        .entry_err   (entry_err),
        .led         (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int kind;   // 1 = num_rdy, 2 = entry_err
        int n1, n2, n3;
        int cnt;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   total_cnt = 0;
    int   pass_cnt  = 0;

    task automatic chk(input string name, input int act, input int exp_v);
        total_cnt++;
        if (act == exp_v) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    endtask

    task automatic push_rdy(input int a, input int b, input int c);
        exp_t x;
        x.kind = 1; x.n1 = a; x.n2 = b; x.n3 = c; x.cnt = 0;
        sb.push_back(x);
    endtask

    task automatic push_err(input int cnt);
        exp_t x;
        x.kind = 2; x.n1 = 0; x.n2 = 0; x.n3 = 0; x.cnt = cnt;
        sb.push_back(x);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        scan_code  = b;
        scan_valid = 1'b1;
        @(negedge clk);
        scan_valid = 1'b0;
        scan_code  = 8'h00;
    endtask

    task automatic send_seq(input logic [7:0] seq [$]);
        foreach (seq[i]) send(seq[i]);
    endtask

    // Monitor: every strobe the DUT raises must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && (num_rdy || entry_err)) begin
            if (sb.size() == 0) begin
                chk("unexpected_strobe", {num_rdy, entry_err}, 0);
            end else begin
                e = sb.pop_front();
                chk("strobe_kind", num_rdy ? (entry_err ? 3 : 1) : 2, e.kind);
                chk("strobe_count", entry_count, e.cnt);
                if (e.kind == 1) begin
                    chk("num1", num1, e.n1);
                    chk("num2", num2, e.n2);
                    chk("num3", num3, e.n3);
                end
            end
        end
    end

    initial begin
        reset      = 1'b1;
        scan_code  = 8'h00;
        scan_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_num1", num1, 0);
        chk("rst_num2", num2, 0);
        chk("rst_num3", num3, 0);
        chk("rst_rdy", num_rdy, 0);
        chk("rst_err", entry_err, 0);
        chk("rst_count", entry_count, 0);
        chk("rst_led", led, 0);
        reset = 1'b0;
        @(negedge clk);

        // 1) main row with break codes
        push_rdy(1, 2, 3);
        send_seq('{8'h16, 8'hF0, 8'h16, 8'h1E, 8'hF0, 8'h1E, 8'h26, 8'hF0, 8'h26, 8'h5A});
        chk("t1_count", entry_count, 0);
        chk("t1_led", led, 8'h23);

        // 2) numpad + E0 5A, then released numpad Enter gives nothing
        push_rdy(1, 2, 3);
        send_seq('{8'h69, 8'h72, 8'h7A, 8'hE0, 8'h5A});
        send_seq('{8'hE0, 8'hF0, 8'h5A});
        chk("t2_count", entry_count, 0);

        // 3) early Enter rejected, buffer kept
        push_err(2);
        send_seq('{8'h16, 8'h1E, 8'h5A});
        chk("t3_count", entry_count, 2);
        chk("t3_led", led, 8'h92);
        push_rdy(1, 2, 3);
        send_seq('{8'h26, 8'h5A});

        // 4) backspace mid-entry and at count 0; outputs hold during next entry
        push_rdy(1, 3, 6);
        send_seq('{8'h16, 8'h1E, 8'h66, 8'h26, 8'h36, 8'h5A});
        send(8'h66);
        chk("t4_bksp0_count", entry_count, 0);
        send(8'h16);
        chk("t4_hold_num1", num1, 1);
        chk("t4_hold_num2", num2, 3);
        chk("t4_hold_num3", num3, 6);
        chk("t4_count", entry_count, 1);
        send(8'h66);

        // prefix arriving in S_BREAK is the discarded byte
        send_seq('{8'hF0, 8'hE0, 8'h16});
        chk("pfx_count", entry_count, 1);
        send(8'h66);

        // 5) fourth digit rejected, then reset mid-entry
        push_err(3);
        send_seq('{8'h16, 8'h1E, 8'h26, 8'h36});
        chk("t5_count", entry_count, 3);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("t5_rst_count", entry_count, 0);
        chk("t5_rst_num1", num1, 0);
        chk("t5_rst_led", led, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // 6) duplicate digits
`ifdef DISTINCT_DIGITS_EN
        push_err(1);
        send_seq('{8'h16, 8'h16});
        chk("t6_count", entry_count, 1);
        send(8'h66);
`else
        send_seq('{8'h16, 8'h16});
        chk("t6_count", entry_count, 2);
        push_rdy(1, 1, 1);
        send_seq('{8'h16, 8'h5A});
`endif

        repeat (5) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
